// File: rtl/radix4_divider.sv
// radix4_divider: sequential signed integer divider, two restoring
// subtract-shift steps (two quotient bits) per clock.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   start                request a division while idle (ignored when busy)
//   dividend, divisor    signed operands, captured on the accepting edge
//   busy                 division in progress
//   done                 one-cycle pulse, results valid from this cycle on
//   quotient, remainder  truncated signed results, held until next done
//   div_by_zero,overflow flags for the last completed operation
module radix4_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int HALF = WIDTH / 2;
   localparam int CW   = $clog2(HALF + 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state;
   logic [WIDTH:0]   p;       // partial remainder, one spare bit for the compare
   logic [WIDTH-1:0] q;       // dividend magnitude shifting out / quotient in
   logic [WIDTH-1:0] d;       // divisor magnitude
   logic [CW-1:0]    cnt;
   logic             sign_q, sign_r;
   logic             spec_dbz, spec_ovf;

   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic [2*WIDTH:0] s1, s2;

   // One restoring step on {P,Q}. After a step P < D <= 2^WIDTH-1, so the
   // shifted P always fits in WIDTH+1 bits.
   function automatic logic [2*WIDTH:0] step(input logic [2*WIDTH:0] pq,
                                             input logic [WIDTH-1:0] dv);
      logic [WIDTH:0]   pn;
      logic [WIDTH-1:0] qn;
      pn = {pq[2*WIDTH-1:WIDTH], pq[WIDTH-1]};
      qn = {pq[WIDTH-2:0], 1'b0};
      if (pn >= {1'b0, dv}) begin
         pn    = pn - {1'b0, dv};
         qn[0] = 1'b1;
      end
      return {pn, qn};
   endfunction

   // Negating the most-negative value yields 2^(WIDTH-1), which is the
   // correct unsigned magnitude.
   always_comb begin
      dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
      dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
      s1      = step({p, q}, d);
      s2      = step(s1, d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         p           <= '0;
         q           <= '0;
         d           <= '0;
         cnt         <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         spec_dbz    <= 1'b0;
         spec_ovf    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               sign_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
               sign_r   <= dividend[WIDTH-1];
               d        <= dvs_mag;
               cnt      <= '0;
               busy     <= 1'b1;
               spec_dbz <= 1'b0;
               spec_ovf <= 1'b0;
               // Special cases park their final results in P/Q and go
               // straight to FIX, which then skips the sign correction.
               if (divisor == '0) begin
                  q        <= '1;
                  p        <= {1'b0, dividend};
                  spec_dbz <= 1'b1;
                  state    <= FIX;
               end else if (dividend == MOST_NEG && divisor == '1) begin
                  q        <= MOST_NEG;
                  p        <= '0;
                  spec_ovf <= 1'b1;
                  state    <= FIX;
               end else begin
                  q     <= dvd_mag;
                  p     <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               p   <= s2[2*WIDTH:WIDTH];
               q   <= s2[WIDTH-1:0];
               cnt <= cnt + 1'b1;
               if (cnt == CW'(HALF - 1)) state <= FIX;
            end
            FIX: begin
               done        <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
               div_by_zero <= spec_dbz;
               overflow    <= spec_ovf;
               if (spec_dbz || spec_ovf) begin
                  quotient  <= q;
                  remainder <= p[WIDTH-1:0];
               end else begin
                  quotient  <= sign_q ? -q : q;
                  remainder <= sign_r ? -p[WIDTH-1:0] : p[WIDTH-1:0];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_radix4_divider.sv
// tb_radix4_divider: table vectors, handshake/reset sequences and random
// operands for radix4_divider (WIDTH=32), checked through a result queue.
module tb_radix4_divider;

   localparam int W = 32;
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   typedef struct {
      logic [W-1:0] a, b, eq, er;
      logic         edbz, eovf;
      int           lat;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend, divisor;
   logic         busy, done, div_by_zero, overflow;
   logic [W-1:0] quotient, remainder;

   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t sb[$];

   radix4_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [2*W+7:0] act,
                        input logic [2*W+7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      vec_t v;
      v.a = a; v.b = b; v.edbz = 1'b0; v.eovf = 1'b0; v.lat = 1;
      if (b == '0) begin
         v.eq = '1; v.er = a; v.edbz = 1'b1;
      end else if (a == MOST_NEG && b == '1) begin
         v.eq = MOST_NEG; v.er = '0; v.eovf = 1'b1;
      end else begin
         v.eq = $signed(a) / $signed(b);
         v.er = $signed(a) % $signed(b);
         v.lat = W/2 + 1;
      end
      return v;
   endfunction

   function automatic vec_t mk(input logic [W-1:0] a, b, eq, er,
                               input logic edbz, eovf, input int lat);
      vec_t v;
      v.a = a; v.b = b; v.eq = eq; v.er = er; v.edbz = edbz; v.eovf = eovf; v.lat = lat;
      return v;
   endfunction

   // Compare every done against the oldest queued expectation.
   task automatic monitor();
      vec_t e;
      logic signed [W-1:0] qs, rs, as_, bs;
      logic [W-1:0] rmag, bmag;
      forever begin
         @(negedge clk);
         if (rst_n && done) begin
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_done: got done=1, expected no done");
            end else begin
               e = sb.pop_front();
               check("result", {quotient, remainder, div_by_zero, overflow},
                     {e.eq, e.er, e.edbz, e.eovf});
               if (!e.edbz && !e.eovf) begin
                  qs = quotient; rs = remainder; as_ = e.a; bs = e.b;
                  rmag = rs[W-1] ? -rs : rs;
                  bmag = bs[W-1] ? -bs : bs;
                  check("inv_recon", W'(qs * bs + rs), as_);
                  check("inv_mag", (rmag < bmag), 1);
                  check("inv_sign", (rs == 0 || rs[W-1] == as_[W-1]), 1);
               end
            end
         end
      end
   endtask

   // Issue one division; optionally poke start with other operands mid-run.
   task automatic do_div(input vec_t v, input bit poke);
      int n;
      @(negedge clk);
      dividend = v.a; divisor = v.b; start = 1'b1;
      sb.push_back(v);
      @(negedge clk);
      start = 1'b0; n = 1;
      check("busy", busy, 1);
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
         if (poke && n == 5) begin
            dividend = 55; divisor = 3; start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      if (n >= 200) check("timeout", 0, 1);
      else          check("latency", n - 1, v.lat);
   endtask

   initial begin
      vec_t tbl[$];
      vec_t v1, v2;
      int   n;
      logic [W-1:0] a, b;

      tbl.push_back(mk(100,          7,          14,           2,           0, 0, 17));
      tbl.push_back(mk(32'hFFFFFF9C, 7,          32'hFFFFFFF2, 32'hFFFFFFFE, 0, 0, 17));
      tbl.push_back(mk(100,          32'hFFFFFFF9, 32'hFFFFFFF2, 2,          0, 0, 17));
      tbl.push_back(mk(32'hFFFFFF9C, 32'hFFFFFFF9, 14,          32'hFFFFFFFE, 0, 0, 17));
      tbl.push_back(mk(32'h7FFFFFFF, 1,          32'h7FFFFFFF, 0,           0, 0, 17));
      tbl.push_back(mk(1234,         0,          32'hFFFFFFFF, 1234,        1, 0, 1));
      tbl.push_back(mk(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0,         0, 1, 1));
      tbl.push_back(mk(9,            3,          3,            0,           0, 0, 17));
      tbl.push_back(mk(0,            5,          0,            0,           0, 0, 17));
      tbl.push_back(mk(32'h80000000, 2,          32'hC0000000, 0,           0, 0, 17));
      tbl.push_back(mk(7,            32'hFFFFFF9C, 0,          7,           0, 0, 17));
      tbl.push_back(mk(32'h80000000, 0,          32'hFFFFFFFF, 32'h80000000, 1, 0, 1));

      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      fork monitor(); join_none
      #2;
      check("reset_outs", {busy, done, quotient, remainder, div_by_zero, overflow}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) do_div(tbl[i], 1'b0);

      // start pulse while busy with other operands must be ignored
      do_div(mk(100, 7, 14, 2, 0, 0, 17), 1'b1);

      // start held high through done: second op accepted in the done cycle
      v1 = ref_div(1000, 13);
      v2 = ref_div(32'hFFFFFFB3, 5);   // -77/5 -> -15 r -2
      @(negedge clk);
      dividend = v1.a; divisor = v1.b; start = 1'b1;
      sb.push_back(v1);
      n = 0;
      while (!done && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) check("timeout_b2b", 0, 1);
      dividend = v2.a; divisor = v2.b;
      sb.push_back(v2);
      @(negedge clk);
      start = 1'b0; n = 1;
      while (!done && n < 200) begin @(negedge clk); n++; end
      check("latency_b2b", n - 1, 17);

      // asynchronous reset between edges aborts a running division
      @(negedge clk);
      dividend = 100; divisor = 7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async", {busy, done, quotient, remainder, div_by_zero, overflow}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      do_div(mk(50, 5, 10, 0, 0, 0, 17), 1'b0);

      // random operands with a mix of divisor magnitudes
      for (int i = 0; i < 1500; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = $urandom;
            1: b = W'($signed($urandom_range(0, 30)) - 15);
            2: begin b = $urandom >> $urandom_range(0, 31); if ($urandom_range(0, 1) == 1) b = -b; end
            default: begin a = a >> $urandom_range(0, 31); b = $urandom >> $urandom_range(16, 31); end
         endcase
         if (i % 97 == 0) a = MOST_NEG;
         do_div(ref_div(a, b), 1'b0);
      end

      repeat (5) @(negedge clk);
      check("queue_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
